// File: rtl/smi_mem_lib_write_burst_multi.sv
// ============================================================================
// smi_mem_lib_write_burst_multi
// Splits one write transaction into 4 KiB-safe bursts and frames the data.
// Revision: 1.0
// ============================================================================
`default_nettype none

module smi_mem_lib_write_burst_multi #(
    parameter int DataWidth      = 64,
    parameter int MaxBurstLen    = 4096 / (DataWidth / 8),
    parameter int MaxOutstanding = 4
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 paramsValid,
    output logic                 paramsStop,
    input  logic [63:0]          paramAddr,
    input  logic [31:0]          paramLen,
    input  logic [7:0]           paramOpts,
    input  logic                 writeValid,
    input  logic [DataWidth-1:0] writeData,
    output logic                 writeStop,
    output logic                 cmdValid,
    input  logic                 cmdStop,
    output logic [63:0]          cmdAddr,
    output logic [15:0]          cmdByteLen,
    output logic [7:0]           cmdOpts,
    output logic                 dataValid,
    output logic [7:0]           dataEofc,
    output logic [DataWidth-1:0] dataData,
    input  logic                 dataStop,
    input  logic                 burstDoneValid,
    input  logic                 burstDoneStatusOk,
    output logic                 burstDoneStop,
    output logic                 doneValid,
    output logic                 doneStatusOk,
    input  logic                 doneStop
);

    localparam int c_BPW     = DataWidth / 8;
    localparam int c_BPW_LOG = $clog2(c_BPW);
    localparam int c_PTR_W   = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int c_CNT_W   = $clog2(MaxOutstanding + 1);

    localparam logic [63:0]        c_ALIGN_MASK = 64'(c_BPW - 1);
    localparam logic [12:0]        c_MAX_BURST  = 13'(MaxBurstLen);
    localparam logic [c_CNT_W-1:0] c_MAX_OUT    = c_CNT_W'(MaxOutstanding);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST   = c_PTR_W'(MaxOutstanding - 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ISSUE  = 2'd1;
    localparam logic [1:0] c_WAIT   = 2'd2;
    localparam logic [1:0] c_REPORT = 2'd3;

    logic [1:0]         r_state;
    logic [63:0]        r_addr;
    logic [31:0]        r_remaining;
    logic [7:0]         r_opts;
    logic               r_status;
    logic [c_CNT_W-1:0] r_outstanding;

    logic [12:0]        r_fifo [MaxOutstanding];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_fifo_cnt;

    logic               r_cp_active;
    logic [12:0]        r_flit_cnt;

    logic [12:0]        w_page_bytes;
    logic [12:0]        w_page_words;
    logic [12:0]        w_cap;
    logic [12:0]        w_words;
    logic               w_cmd_fire;
    logic               w_done_fire;
    logic [c_CNT_W-1:0] w_out_next;
    logic               w_cp_have;
    logic [12:0]        w_cp_cur;
    logic               w_cp_xfer;
    logic               w_pop;

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Burst size: limited by remaining words, burst cap and the next 4 KiB page
    always_comb begin
        w_page_bytes = 13'h1000 - {1'b0, r_addr[11:0]};
        w_page_words = w_page_bytes >> c_BPW_LOG;
        w_cap        = (w_page_words < c_MAX_BURST) ? w_page_words : c_MAX_BURST;
        w_words      = (r_remaining < 32'(w_cap)) ? r_remaining[12:0] : w_cap;
    end

    assign paramsStop    = srst | (r_state != c_IDLE);
    assign cmdValid      = (r_state == c_ISSUE) && (r_outstanding < c_MAX_OUT)
                           && (r_fifo_cnt < c_MAX_OUT);
    assign cmdAddr       = r_addr;
    assign cmdByteLen    = 16'(w_words) << c_BPW_LOG;
    assign cmdOpts       = r_opts;
    assign burstDoneStop = 1'b0;
    assign doneValid     = (r_state == c_REPORT);
    assign doneStatusOk  = doneValid & r_status;

    assign w_cmd_fire  = cmdValid & ~cmdStop;
    assign w_done_fire = burstDoneValid & (r_outstanding != '0);

    always_comb begin
        w_out_next = r_outstanding;
        if (w_cmd_fire && !w_done_fire) begin
            w_out_next = r_outstanding + 1'b1;
        end else if (!w_cmd_fire && w_done_fire) begin
            w_out_next = r_outstanding - 1'b1;
        end
    end

    // The FIFO head is usable in the pop cycle, so bursts follow each other gap-free
    assign w_cp_have = r_cp_active | (r_fifo_cnt != '0);
    assign w_cp_cur  = r_cp_active ? r_flit_cnt : r_fifo[r_rd_ptr];
    assign dataValid = w_cp_have & writeValid;
    assign writeStop = ~w_cp_have | dataStop;
    assign dataData  = writeData;
    assign dataEofc  = (w_cp_have && (w_cp_cur == 13'd1)) ? 8'(c_BPW) : 8'd0;
    assign w_cp_xfer = dataValid & ~dataStop;
    assign w_pop     = w_cp_xfer & ~r_cp_active;

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            r_state       <= c_IDLE;
            r_addr        <= '0;
            r_remaining   <= '0;
            r_opts        <= '0;
            r_status      <= 1'b0;
            r_outstanding <= '0;
        end else begin
            r_outstanding <= w_out_next;
            if ((r_state == c_IDLE) && paramsValid) begin
                r_status <= 1'b1;
            end else if (w_done_fire) begin
                r_status <= r_status & burstDoneStatusOk;
            end
            case (r_state)
                c_IDLE: begin
                    if (paramsValid) begin
                        r_addr      <= paramAddr & ~c_ALIGN_MASK;
                        r_remaining <= paramLen;
                        r_opts      <= paramOpts;
                        r_state     <= (paramLen == 32'd0) ? c_REPORT : c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    if (w_cmd_fire) begin
                        r_addr      <= r_addr + 64'(cmdByteLen);
                        r_remaining <= r_remaining - 32'(w_words);
                        if (r_remaining == 32'(w_words)) begin
                            r_state <= c_WAIT;
                        end
                    end
                end
                c_WAIT: begin
                    if (w_out_next == '0) begin
                        r_state <= c_REPORT;
                    end
                end
                c_REPORT: begin
                    if (!doneStop) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fifo_cnt  <= '0;
            r_cp_active <= 1'b0;
            r_flit_cnt  <= '0;
        end else begin
            if (w_cmd_fire) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_cmd_fire && !w_pop) begin
                r_fifo_cnt <= r_fifo_cnt + 1'b1;
            end else if (!w_cmd_fire && w_pop) begin
                r_fifo_cnt <= r_fifo_cnt - 1'b1;
            end
            if (w_cp_xfer) begin
                if (w_cp_cur == 13'd1) begin
                    r_cp_active <= 1'b0;
                end else begin
                    r_cp_active <= 1'b1;
                    r_flit_cnt  <= w_cp_cur - 13'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_cmd_fire) begin
            r_fifo[r_wr_ptr] <= w_words;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_smi_mem_lib_write_burst_multi.sv
// ============================================================================
// tb_smi_mem_lib_write_burst_multi
// Self-checking bench: randomized handshakes against a burst-splitting model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_smi_mem_lib_write_burst_multi;

    localparam int DW  = 64;
    localparam int BPW = 8;
    localparam int MBL = 512;
    localparam int MO  = 2;

    logic          clk = 1'b0;
    logic          srst = 1'b1;
    logic          paramsValid = 1'b0;
    logic          paramsStop;
    logic [63:0]   paramAddr = '0;
    logic [31:0]   paramLen = '0;
    logic [7:0]    paramOpts = '0;
    logic          writeValid = 1'b0;
    logic [DW-1:0] writeData = '0;
    logic          writeStop;
    logic          cmdValid;
    logic          cmdStop = 1'b0;
    logic [63:0]   cmdAddr;
    logic [15:0]   cmdByteLen;
    logic [7:0]    cmdOpts;
    logic          dataValid;
    logic [7:0]    dataEofc;
    logic [DW-1:0] dataData;
    logic          dataStop = 1'b0;
    logic          burstDoneValid = 1'b0;
    logic          burstDoneStatusOk = 1'b0;
    logic          burstDoneStop;
    logic          doneValid;
    logic          doneStatusOk;
    logic          doneStop = 1'b0;

    smi_mem_lib_write_burst_multi #(
        .DataWidth(DW), .MaxBurstLen(MBL), .MaxOutstanding(MO)
    ) dut (
        .clk(clk), .srst(srst),
        .paramsValid(paramsValid), .paramsStop(paramsStop),
        .paramAddr(paramAddr), .paramLen(paramLen), .paramOpts(paramOpts),
        .writeValid(writeValid), .writeData(writeData), .writeStop(writeStop),
        .cmdValid(cmdValid), .cmdStop(cmdStop), .cmdAddr(cmdAddr),
        .cmdByteLen(cmdByteLen), .cmdOpts(cmdOpts),
        .dataValid(dataValid), .dataEofc(dataEofc), .dataData(dataData), .dataStop(dataStop),
        .burstDoneValid(burstDoneValid), .burstDoneStatusOk(burstDoneStatusOk),
        .burstDoneStop(burstDoneStop),
        .doneValid(doneValid), .doneStatusOk(doneStatusOk), .doneStop(doneStop)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Environment knobs and observations
    bit          rand_stops = 1'b0;
    bit          full_rate = 1'b1;
    bit          hold_dones = 1'b0;
    int          fail_idx = -1;
    bit          wr_xfer = 1'b0;
    logic [63:0] got_addr[$];
    logic [15:0] got_blen[$];
    logic [7:0]  got_opts[$];
    int          got_words[$];
    int          got_flits, flit_in_burst, pass_err, pend, done_idx;
    int          out_now, max_out, first_flit, last_flit, cyc;
    logic [63:0] exp_addr[$];
    int          exp_words[$];

    task automatic clear_state();
        got_addr.delete(); got_blen.delete(); got_opts.delete(); got_words.delete();
        got_flits = 0; flit_in_burst = 0; pass_err = 0; pend = 0; done_idx = 0;
        out_now = 0; max_out = 0; first_flit = 0; last_flit = 0;
    endtask

    // Monitor: samples on the falling edge, away from the active edge
    initial begin
        cyc = 0;
        clear_state();
        forever begin
            @(negedge clk);
            cyc++;
            wr_xfer = writeValid && !writeStop;
            if (!srst) begin
                if (cmdValid && !cmdStop) begin
                    got_addr.push_back(cmdAddr);
                    got_blen.push_back(cmdByteLen);
                    got_opts.push_back(cmdOpts);
                    out_now++;
                end
                if (burstDoneValid) out_now--;
                if (out_now > max_out) max_out = out_now;
                if (dataValid && (writeStop !== dataStop)) pass_err++;
                if (dataValid && !dataStop) begin
                    if (dataData !== writeData) pass_err++;
                    if (got_flits == 0) first_flit = cyc;
                    last_flit = cyc;
                    got_flits++;
                    flit_in_burst++;
                    if (dataEofc != 8'd0) begin
                        if (dataEofc != 8'(BPW)) pass_err++;
                        got_words.push_back(flit_in_burst);
                        flit_in_burst = 0;
                        pend++;
                    end
                end
            end
        end
    end

    // Driver: write source, command/data sinks and burst-core completions
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cmdStop  = rand_stops && ($urandom_range(0, 2) == 0);
            dataStop = rand_stops && ($urandom_range(0, 2) == 0);
            if (!writeValid || wr_xfer) begin
                writeValid = full_rate || ($urandom_range(0, 3) != 0);
                writeData  = {$urandom, $urandom};
            end
            burstDoneValid    = 1'b0;
            burstDoneStatusOk = 1'b0;
            if (!srst && !hold_dones && pend > 0 && (full_rate || $urandom_range(0, 1) == 1)) begin
                burstDoneValid    = 1'b1;
                burstDoneStatusOk = (done_idx != fail_idx);
                done_idx++;
                pend--;
            end
        end
    end

    // Reference: split a transaction into page-safe bursts with plain arithmetic
    task automatic build_expect(input logic [63:0] addr, input int len);
        logic [63:0] a;
        int rem, page, w;
        exp_addr.delete(); exp_words.delete();
        a = addr & ~64'(BPW - 1);
        rem = len;
        while (rem > 0) begin
            page = (4096 - int'(a % 4096)) / BPW;
            w = rem;
            if (w > MBL) w = MBL;
            if (w > page) w = page;
            exp_addr.push_back(a);
            exp_words.push_back(w);
            a = a + 64'(w * BPW);
            rem -= w;
        end
    endtask

    task automatic send_params(input logic [63:0] addr, input int len, input logic [7:0] opts);
        bit acc = 1'b0;
        @(posedge clk); #2;
        paramsValid = 1'b1; paramAddr = addr; paramLen = 32'(len); paramOpts = opts;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!paramsStop) begin acc = 1'b1; break; end
        end
        @(posedge clk); #2;
        paramsValid = 1'b0;
        if (!acc) begin
            total++; bad++;
            $display("FAIL params_accept got=timeout expected=accept");
        end
    endtask

    task automatic wait_done(output bit ok, output int lat);
        bit seen = 1'b0;
        ok = 1'b0; lat = 0;
        doneStop = 1'b0;
        for (int i = 1; i <= 20000; i++) begin
            @(negedge clk);
            if (doneValid && !doneStop) begin ok = doneStatusOk; lat = i; seen = 1'b1; break; end
            @(posedge clk); #2;
            doneStop = rand_stops && ($urandom_range(0, 1) == 1);
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL done_timeout got=none expected=doneValid");
        end
        @(posedge clk); #2;
        doneStop = 1'b0;
    endtask

    // Compare everything observed for one transaction against the model
    task automatic check_txn(input string nm, input logic [63:0] addr, input int len,
                             input logic [7:0] opts, input bit ok);
        bit exp_ok;
        build_expect(addr, len);
        exp_ok = !(fail_idx >= 0 && fail_idx < exp_addr.size());
        total++;
        if (got_addr.size() != exp_addr.size()) begin
            bad++;
            $display("FAIL %s ncmd got=%0d expected=%0d", nm, got_addr.size(), exp_addr.size());
        end else begin
            for (int i = 0; i < exp_addr.size(); i++) begin
                total++;
                if (got_addr[i] !== exp_addr[i] || got_blen[i] !== 16'(exp_words[i] * BPW)
                    || got_opts[i] !== opts) begin
                    bad++;
                    $display("FAIL %s cmd%0d got=%h/%0d/%h expected=%h/%0d/%h", nm, i,
                             got_addr[i], got_blen[i], got_opts[i],
                             exp_addr[i], exp_words[i] * BPW, opts);
                end
            end
        end
        total++;
        if (got_words.size() != exp_words.size()) begin
            bad++;
            $display("FAIL %s nbursts got=%0d expected=%0d", nm, got_words.size(), exp_words.size());
        end else begin
            for (int i = 0; i < exp_words.size(); i++) begin
                total++;
                if (got_words[i] != exp_words[i]) begin
                    bad++;
                    $display("FAIL %s eofc_pos%0d got=%0d expected=%0d", nm, i, got_words[i], exp_words[i]);
                end
            end
        end
        total++;
        if (got_flits != len) begin
            bad++; $display("FAIL %s flits got=%0d expected=%0d", nm, got_flits, len);
        end
        total++;
        if (pass_err != 0) begin
            bad++; $display("FAIL %s passthrough got=%0d errors expected=0", nm, pass_err);
        end
        total++;
        if (max_out > MO) begin
            bad++; $display("FAIL %s outstanding got=%0d expected<=%0d", nm, max_out, MO);
        end
        total++;
        if (ok !== exp_ok) begin
            bad++; $display("FAIL %s status got=%0b expected=%0b", nm, ok, exp_ok);
        end
    endtask

    task automatic run_txn(input string nm, input logic [63:0] addr, input int len, input logic [7:0] opts);
        bit ok; int lat;
        clear_state();
        send_params(addr, len, opts);
        wait_done(ok, lat);
        check_txn(nm, addr, len, opts, ok);
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({paramsStop, cmdValid, dataValid, writeStop, doneValid, doneStatusOk, burstDoneStop} !== 7'b1001000) begin
            bad++;
            $display("FAIL reset_outputs got=%b expected=1001000",
                     {paramsStop, cmdValid, dataValid, writeStop, doneValid, doneStatusOk, burstDoneStop});
        end
        @(posedge clk); #2;
        srst = 1'b0;
        @(negedge clk);
        total++;
        if (paramsStop !== 1'b0) begin
            bad++; $display("FAIL idle_paramsStop got=%b expected=0", paramsStop);
        end
    endtask

    task automatic test_single();
        bit ok; int lat;
        rand_stops = 1'b0; full_rate = 1'b1; fail_idx = -1;
        clear_state();
        send_params(64'h1000, 512, 8'hA3);
        @(negedge clk);
        total++;
        if (cmdValid !== 1'b1 || cmdAddr !== 64'h1000) begin
            bad++; $display("FAIL first_cmd got=%b/%h expected=1/1000", cmdValid, cmdAddr);
        end
        wait_done(ok, lat);
        check_txn("single", 64'h1000, 512, 8'hA3, ok);
        total++;
        if (last_flit - first_flit != 511) begin
            bad++; $display("FAIL single_rate got=%0d expected=511", last_flit - first_flit);
        end
    endtask

    task automatic test_cross();
        rand_stops = 1'b0; full_rate = 1'b1; fail_idx = -1;
        run_txn("cross", 64'h0FF8, 3, 8'h11);
        run_txn("unaligned", 64'h0FFD, 3, 8'h12);
    endtask

    task automatic test_back_to_back();
        rand_stops = 1'b0; full_rate = 1'b1; fail_idx = -1;
        run_txn("b2b", 64'h0, 1024, 8'h22);
        total++;
        if (last_flit - first_flit != 1023) begin
            bad++; $display("FAIL b2b_rate got=%0d expected=1023", last_flit - first_flit);
        end
    endtask

    task automatic test_throttle();
        bit ok; int lat;
        rand_stops = 1'b0; full_rate = 1'b1; fail_idx = -1; hold_dones = 1'b1;
        clear_state();
        send_params(64'h0, 2000, 8'h33);
        repeat (40) @(negedge clk);
        total++;
        if (got_addr.size() != 2 || cmdValid !== 1'b0) begin
            bad++; $display("FAIL throttle_hold got=%0d/%b expected=2/0", got_addr.size(), cmdValid);
        end
        repeat (1100) @(negedge clk);
        total++;
        if (got_addr.size() != 2 || got_flits != 1024) begin
            bad++; $display("FAIL throttle_drain got=%0d/%0d expected=2/1024", got_addr.size(), got_flits);
        end
        @(posedge clk); #2;
        hold_dones = 1'b0;
        wait_done(ok, lat);
        check_txn("throttle", 64'h0, 2000, 8'h33, ok);
    endtask

    task automatic test_status();
        rand_stops = 1'b0; full_rate = 1'b1;
        fail_idx = 2;
        run_txn("status_bad", 64'h0, 2048, 8'h44);
        fail_idx = -1;
        run_txn("status_good", 64'h40, 10, 8'h45);
    endtask

    task automatic test_zero_len();
        bit ok; int lat;
        rand_stops = 1'b0; full_rate = 1'b1; fail_idx = -1;
        clear_state();
        send_params(64'h1234, 0, 8'h5A);
        wait_done(ok, lat);
        total++;
        if (lat != 1 || ok !== 1'b1) begin
            bad++; $display("FAIL zero_done got=lat%0d/ok%b expected=lat1/ok1", lat, ok);
        end
        total++;
        if (got_addr.size() != 0 || got_flits != 0) begin
            bad++; $display("FAIL zero_traffic got=%0d/%0d expected=0/0", got_addr.size(), got_flits);
        end
        @(negedge clk);
        total++;
        if (paramsStop !== 1'b0) begin
            bad++; $display("FAIL zero_idle got=%b expected=0", paramsStop);
        end
    endtask

    task automatic test_random();
        logic [63:0] a; int len; logic [7:0] o;
        rand_stops = 1'b1; full_rate = 1'b0;
        for (int t = 0; t < 6; t++) begin
            a = {$urandom, $urandom};
            if (t == 2) a = 64'hFFFF_FFFF_FFFF_FF00 | 64'($urandom_range(0, 255));
            len = $urandom_range(0, 1300);
            o = 8'($urandom);
            fail_idx = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : -1;
            run_txn($sformatf("rand%0d", t), a, len, o);
        end
        fail_idx = -1;
    endtask

    task automatic test_mid_reset();
        rand_stops = 1'b1; full_rate = 1'b0; fail_idx = -1;
        clear_state();
        send_params(64'h800, 1500, 8'h66);
        repeat (30) @(posedge clk);
        #3;
        srst = 1'b1;
        #1;
        total++;
        if ({paramsStop, cmdValid, dataValid, writeStop, doneValid, doneStatusOk, burstDoneStop} !== 7'b1001000) begin
            bad++;
            $display("FAIL midreset_outputs got=%b expected=1001000",
                     {paramsStop, cmdValid, dataValid, writeStop, doneValid, doneStatusOk, burstDoneStop});
        end
        @(negedge clk); #1;
        clear_state();
        @(posedge clk); @(posedge clk); #2;
        srst = 1'b0;
        run_txn("after_reset", 64'h2FF0, 700, 8'h77);
    endtask

    initial begin
        test_reset();
        test_single();
        test_cross();
        test_back_to_back();
        test_throttle();
        test_status();
        test_zero_len();
        test_random();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
